// File: rtl/sipo_rx.sv
`default_nettype none
// ============================================================================
// Module   : sipo_rx
// Purpose  : Serial-in, parallel-out receiver. Assembles LSB-first bits into
//            bytes and queues completed bytes in a DEPTH-entry FIFO with a
//            valid/ready output handshake and a sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_rx #(
  parameter int DEPTH = 4
) (
  input  logic                     sclk_i,
  input  logic                     rst_i,
  input  logic                     data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic                     flush_i,
  output logic [7:0]               data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overrun_o
);

  localparam int                c_AW       = $clog2(DEPTH);
  localparam logic [c_AW:0]     c_FULL     = (c_AW+1)'(DEPTH);
  localparam logic [c_AW:0]     c_LVL_ONE  = (c_AW+1)'(1);
  localparam logic [c_AW-1:0]   c_PTR_ONE  = c_AW'(1);
  localparam logic [2:0]        c_LAST_BIT = 3'd7;

  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic [7:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_AW:0]   r_level;
  logic            r_overrun;

  logic            w_valid;
  logic            w_pop;
  logic            w_full;
  logic            w_ready;
  logic            w_accept;
  logic            w_push;

  // Handshake decode: a stall only occurs when the byte about to complete has
  // nowhere to go, i.e. last bit pending, FIFO full and no pop freeing a slot.
  // Reset forces ready high so the port reads as an empty buffer.
  always_comb begin
    w_valid  = (r_level != '0);
    w_pop    = w_valid & ready_i;
    w_full   = (r_level == c_FULL);
    w_ready  = rst_i | ~((r_bitcnt == c_LAST_BIT) & w_full & ~w_pop);
    w_accept = valid_i & w_ready & ~flush_i;
    w_push   = w_accept & (r_bitcnt == c_LAST_BIT);
  end

  assign ready_o   = w_ready;
  assign valid_o   = w_valid;
  assign level_o   = r_level;
  assign overrun_o = r_overrun;
  // Masked so the output reads zero whenever nothing is buffered, without
  // needing to clear the storage array.
  assign data_o    = w_valid ? r_mem[r_rptr] : 8'h00;

  // Bit assembly: accepted bit k lands in shift position k; flush discards
  // the partial byte without touching buffered bytes.
  always_ff @(posedge sclk_i) begin
    if (rst_i) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else if (flush_i) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else if (w_accept) begin
      r_shift[r_bitcnt] <= data_i;
      r_bitcnt          <= r_bitcnt + 3'd1;
    end
  end

  // Byte storage: the completed byte is the 7 held bits plus the bit arriving
  // on this edge, written straight into the tail slot.
  always_ff @(posedge sclk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= {data_i, r_shift[6:0]};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keeps the level.
  always_ff @(posedge sclk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LVL_ONE;
        2'b01:   r_level <= r_level - c_LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overrun: a real bit (not one being flushed) offered while stalled.
  always_ff @(posedge sclk_i) begin
    if (rst_i) begin
      r_overrun <= 1'b0;
    end else if (valid_i & ~w_ready & ~flush_i) begin
      r_overrun <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sipo_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_rx
// Purpose  : Self-checking bench for sipo_rx. Stimulus pushes expected bytes
//            into a queue; a monitor pops and compares on every output pop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_rx;

  localparam int c_DEPTH = 4;

  logic        sclk_i;
  logic        rst_i;
  logic        data_i;
  logic        valid_i;
  logic        ready_o;
  logic        flush_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic [2:0]  level_o;
  logic        overrun_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q [$];

  sipo_rx #(.DEPTH(c_DEPTH)) u_dut (
    .sclk_i    (sclk_i),
    .rst_i     (rst_i),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .flush_i   (flush_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .level_o   (level_o),
    .overrun_o (overrun_o)
  );

  // Free-running clock, 10 time-unit period.
  initial sclk_i = 1'b0;
  always #5 sclk_i = ~sclk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every pop the DUT will perform on the next edge is
  // compared against the oldest expected byte.
  always @(negedge sclk_i) begin
    if (!rst_i && valid_o === 1'b1 && ready_i === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h expected no byte", data_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_o !== e) begin
          n_fail++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h", data_o, e);
        end
      end
    end
  end

  // One bit offered for one edge; returns 1 time unit after that edge.
  task automatic send_bit(input logic b);
    data_i  = b;
    valid_i = 1'b1;
    @(posedge sclk_i);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_bit(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  // Bounded drain wait; an expired bound is reported as a failure.
  task automatic wait_empty(input string name, input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(posedge sclk_i);
      #1;
      if (level_o == 3'd0) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: level_o=%0d after %0d cycles, expected 0", name, level_o, max_cycles);
    end
  endtask

  initial begin
    rst_i   = 1'b1;
    data_i  = 1'b0;
    valid_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    repeat (2) @(posedge sclk_i);
    #1;
    rst_i = 1'b0;

    // Reset state
    @(negedge sclk_i);
    chk("rst_valid",   valid_o,   0);
    chk("rst_level",   level_o,   0);
    chk("rst_data",    data_o,    8'h00);
    chk("rst_overrun", overrun_o, 0);
    chk("rst_ready",   ready_o,   1);
    @(posedge sclk_i);
    #1;

    // Single byte A5 with consumer ready
    ready_i = 1'b1;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    @(negedge sclk_i);
    chk("a5_valid", valid_o, 1);
    chk("a5_level", level_o, 1);
    @(posedge sclk_i);
    #1;
    chk("a5_level_after_pop", level_o, 0);
    chk("a5_valid_after_pop", valid_o, 0);

    // Fill with no consumer, then push+pop on the same edge while full
    ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    send_bits(8'h05, 7);
    @(negedge sclk_i);
    chk("fill_level", level_o, 4);
    chk("fill_ready_stall", ready_o, 0);
    chk("fill_head", data_o, 8'h01);
    @(posedge sclk_i);
    #1;
    ready_i = 1'b1;
    data_i  = 1'b0;
    valid_i = 1'b1;
    @(negedge sclk_i);
    chk("full_pushpop_ready", ready_o, 1);
    @(posedge sclk_i);
    #1;
    valid_i = 1'b0;
    chk("full_pushpop_level", level_o, 4);
    wait_empty("fill_drain", 20);
    chk("fill_overrun", overrun_o, 0);

    // Overrun: full buffer, counter at 7, keep offering bits with no consumer
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
    send_bits(8'h14, 7);
    data_i  = 1'b1;
    valid_i = 1'b1;
    repeat (3) @(posedge sclk_i);
    #1;
    valid_i = 1'b0;
    @(negedge sclk_i);
    chk("ovr_set",   overrun_o, 1);
    chk("ovr_level", level_o,   4);
    chk("ovr_ready", ready_o,   0);
    repeat (3) @(posedge sclk_i);
    #1;
    chk("ovr_sticky", overrun_o, 1);
    ready_i = 1'b1;
    wait_empty("ovr_drain", 20);

    // Flush: clear leftover partial byte, 3 bits, flush with a bit offered, 3C
    flush_i = 1'b1;
    @(posedge sclk_i);
    #1;
    flush_i = 1'b0;
    send_bits(8'h07, 3);
    flush_i = 1'b1;
    data_i  = 1'b1;
    valid_i = 1'b1;
    @(posedge sclk_i);
    #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    exp_q.push_back(8'h3C);
    send_byte(8'h3C);
    @(negedge sclk_i);
    chk("flush_level", level_o, 1);
    wait_empty("flush_drain", 10);
    chk("flush_overrun_sticky", overrun_o, 1);

    // Mid-operation reset with two bytes and a partial byte held
    ready_i = 1'b0;
    send_byte(8'h55);
    send_byte(8'hAA);
    send_bits(8'h0F, 4);
    @(negedge sclk_i);
    chk("mid_level_before", level_o, 2);
    @(posedge sclk_i);
    #1;
    rst_i   = 1'b1;
    data_i  = 1'b0;
    valid_i = 1'b1;
    @(negedge sclk_i);
    chk("mid_ready_in_reset", ready_o, 1);
    @(posedge sclk_i);
    #1;
    rst_i   = 1'b0;
    valid_i = 1'b0;
    @(negedge sclk_i);
    chk("mid_valid",   valid_o,   0);
    chk("mid_level",   level_o,   0);
    chk("mid_data",    data_o,    8'h00);
    chk("mid_overrun", overrun_o, 0);
    @(posedge sclk_i);
    #1;
    ready_i = 1'b1;
    exp_q.push_back(8'hFF);
    send_byte(8'hFF);
    @(negedge sclk_i);
    chk("mid_ff_level", level_o, 1);
    wait_empty("mid_drain", 10);

    repeat (3) @(posedge sclk_i);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 Parameter: DEPTH, 4, number of entries in the output byte buffer (power of two, 2..16).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port: sclk_i  input  1  serial-domain clock; all logic on its rising edge.
REQ-004 Port: rst_i  input  1  synchronous active-high reset.
REQ-005 Port: data_i  input  1  serial data bit, LSB of each byte first.
REQ-006 Port: valid_i  input  1  data_i holds a valid bit.
REQ-007 Port: ready_o  output  1  block can accept a bit this cycle.
REQ-008 Port: flush_i  input  1  discard the partially assembled byte.
REQ-009 Port: data_o  output  8  assembled byte at the head of the buffer.
REQ-010 Port: valid_o  output  1  data_o is valid.
REQ-011 Port: ready_i  input  1  consumer accepts data_o this cycle.
REQ-012 Port: level_o  output  $clog2(DEPTH)+1  number of bytes currently buffered.
REQ-013 Port: overrun_o  output  1  sticky flag: a bit was presented while ready_o was low.

Function
REQ-014 A bit SHALL be accepted on a rising edge where valid_i=1 and ready_o=1.
- Accepted bit k goes to shift-register position k (k = bit counter 0..7).
- The bit counter then increments.
REQ-015 On acceptance of bit 7, the completed byte SHALL be written into the buffer tail in the same edge.
- The bit counter wraps to 0.
- The new byte becomes visible on data_o/valid_o one cycle later if the buffer was empty (latency of last bit to valid_o = 1 cycle).
REQ-016 ready_o SHALL be 0 only when all three hold: bit counter=7, buffer holds DEPTH bytes, and no pop occurs this cycle (valid_o=1 and ready_i=1). Otherwise ready_o=1.
- This is combinational: a pop and a push SHALL complete on the same edge when full.
REQ-017 A byte SHALL be popped on a rising edge where valid_o=1 and ready_i=1.
- data_o SHALL show the next entry the following cycle, in FIFO order.
REQ-018 Simultaneous push and pop SHALL leave level_o unchanged.
- Read/write pointers SHALL wrap modulo DEPTH.
REQ-019 data_o and valid_o SHALL stay stable while valid_o=1 and ready_i=0.
REQ-020 valid_o SHALL equal (level_o != 0).
REQ-021 flush_i=1 SHALL clear the bit counter and shift register on that edge and SHALL NOT affect buffered bytes.
- A bit presented with flush_i=1 SHALL be dropped and SHALL NOT set overrun_o.
- ready_o is unaffected by flush_i.
REQ-022 overrun_o SHALL set on any edge where valid_i=1, ready_o=0 and flush_i=0.
- It SHALL stay set until reset.
REQ-023 valid_i=0 cycles between bits SHALL NOT alter the counter or the shift register (gaps allowed).
REQ-024 ready_i SHALL be ignored while valid_o=0; there is no pop from an empty buffer.

Reset
REQ-025 While rst_i=1 at a rising edge, the following SHALL clear, overriding all other inputs:
- bit counter=0, shift register=0
- read/write pointers=0, level_o=0
- valid_o=0, data_o=8'h00, overrun_o=0
REQ-026 During reset ready_o SHALL read 1 (empty buffer); bits presented on the reset edge SHALL be dropped.
REQ-027 Reset asserted mid-byte or with bytes buffered SHALL discard all partial and buffered data.

Verification
REQ-028 Single byte: send bits 1,0,1,0,0,1,0,1 (LSB first), ready_i=1 -> valid_o=1 with data_o=8'hA5 one cycle after the 8th bit, level_o=1, then 0 after the pop.
REQ-029 Fill with no consumer: ready_i=0, send 5 bytes 8'h01..8'h05 (DEPTH=4) -> level_o=4 and ready_o=0 at bit 7 of byte 5 -> raise ready_i -> bytes 01,02,03,04,05 in order, overrun_o=0.
REQ-030 Overrun: buffer full, counter=7, keep valid_i=1 with ready_i=0 -> overrun_o=1 and stays 1; buffer contents are unchanged.
REQ-031 Full push+pop: level_o=4, counter=7, ready_i=1 with the last bit -> ready_o=1, level_o stays 4, the new byte is appended at the tail.
REQ-032 Flush: send 3 bits, pulse flush_i, then send 8'h3C -> data_o=8'h3C and the earlier bits do not appear.
REQ-033 Mid-operation reset: 2 bytes buffered plus 4 bits partial, pulse rst_i -> valid_o=0, level_o=0, next 8 bits (8'hFF) yield data_o=8'hFF.
